calc_key_sequencer: RTL and testbench
=====================================

# calc_key_sequencer

Turns the 4-bit key codes from the on-screen keypad hit-test stage into complete calculator operations. It detects each new key press, accumulates decimal digits into two binary operands, latches the operator, and on `=` issues operand A, operand B and opcode to the arithmetic unit through a valid/ready handshake. It also drives the value currently being typed to the display path.

## Interface
Parameters:
- `WIDTH`, 16: operand and display width in bits.
- `MAX_DIGITS`, 4: maximum decimal digits per operand. 10^MAX_DIGITS−1 must fit in WIDTH.
- `DEBOUNCE_CYCLES`, 4: stability window, used only when `KEY_DEBOUNCE_EN` is defined.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: synchronous, active-high reset.
- `key_code`, in, 4: 0 = no key; 1–9 = digits 1–9; 15 = digit 0; 10 `+`, 11 `-`, 12 `*`, 13 `/`, 14 `=`.
- `operand_a`, out, WIDTH: first operand; stable while `op_valid`.
- `operand_b`, out, WIDTH: second operand; stable while `op_valid`.
- `opcode`, out, 2: 00 add, 01 sub, 10 mul, 11 div.
- `op_valid`, out, 1: operation is available to the arithmetic unit.
- `op_ready`, in, 1: arithmetic unit accepts the operation.
- `display_value`, out, WIDTH: operand currently being entered.
- `entry_state`, out, 2: 00 S_A, 01 S_B, 10 S_ISSUE.

## Operation
Press detection:
- A key is accepted at a rising edge when `key_code != 0` and the registered previous `key_code == 0`.
- One press yields exactly one acceptance, however long the key is held.
- A change from one nonzero code directly to another nonzero code is not accepted.

Digit append:
- `op = op*10 + d`, where code 15 maps to d = 0.
- Only applied while the digit count is below MAX_DIGITS. Further digits are silently dropped.
- The count increments only on an applied digit.

States:
- **S_A:** a digit appends to A.
  - An operator latches `opcode` and moves to S_B. If A has no digits, A = 0.
  - `=` is ignored.
- **S_B:** a digit appends to B.
  - An operator key before any B digit replaces `opcode`; after a B digit it is ignored.
  - `=` with at least one B digit moves to S_ISSUE; with none it is ignored.
- **S_ISSUE:** `op_valid` = 1 and all outputs are held.
  - All keys are ignored, but the press detector keeps tracking so held keys are not re-accepted.
  - When `op_valid && op_ready` is sampled: A, B and both digit counts clear, and the state moves to S_A.

`display_value`:
- Equals A in S_A.
- Equals B in S_B, which shows 0 before any B digit.
- Equals B in S_ISSUE.

Reset: all outputs are 0, the state is S_A, the counts are 0, and the previous-key register is 0.

## Timing
- A key sampled at edge t has its effect (operand, state or `display_value` update) visible after edge t.
- `=` accepted at edge t puts `op_valid` high after edge t.
- `op_valid` stays high until the edge where `op_ready` is sampled high, and drops after that edge. `op_ready` may be high before `op_valid`.
- While `op_valid` is high, `operand_a`, `operand_b` and `opcode` must not change.
- Reset asserted at any time, including during S_ISSUE with `op_valid` high, clears every output at that edge. No operation is issued afterwards.
- The entry path has no combinational path from `key_code` to any output. All outputs are registered.

## Configuration
- `KEY_DEBOUNCE_EN` defined:
  - A key is accepted once `key_code` has held the same nonzero value for DEBOUNCE_CYCLES consecutive cycles, with acceptance at the last of those edges.
  - Re-arming requires `key_code == 0` for DEBOUNCE_CYCLES consecutive cycles.
  - Glitches shorter than the window are never accepted.
- Not defined: single-cycle 0→nonzero edge detection as described in Operation. The `DEBOUNCE_CYCLES` parameter is unused.

## Test plan
- Keys 1, 2 (each held 3 cycles, 0 between), `+`, 3, `=` → `op_valid` high with A=12, B=3, opcode=00. `op_ready` pulse → S_A, `display_value`=0.
- Digits 9,9,9,9,9 into A → A=9999; the fifth digit is dropped and `display_value`=9999.
- 5, `+`, `-`, 2, `*`, `=` → opcode=01 (replaced by `-`, then `*` ignored after a B digit), A=5, B=2.
- 7, `-`, `=` → `=` ignored and state stays S_B. Then code 15, `=` → B=0 issued with opcode 01.
- Hold `op_ready` low for 10 cycles in S_ISSUE while pressing 4 → outputs unchanged; reset in cycle 5 → `op_valid`=0, state S_A, all outputs 0.
- `KEY_DEBOUNCE_EN` with DEBOUNCE_CYCLES=4: code 3 for 3 cycles → no acceptance. Code 3 for 4 cycles → A=3. A 0-gap of 2 cycles followed by code 3 again → no second acceptance.

Source files
------------

// File: rtl/calc_key_sequencer.sv
// -----------------------------------------------------------------------------
// calc_key_sequencer
//
// Purpose:
//   Converts 4-bit key codes from the keypad hit-test stage into complete
//   calculator operations. It detects new key presses, accumulates decimal
//   digits into two binary operands, latches the operator, and on '=' offers
//   operand A, operand B and the opcode to the arithmetic unit through a
//   valid/ready handshake. The operand currently being typed is driven to
//   the display path.
//
// Optional feature macro:
//   KEY_DEBOUNCE_EN - when defined, a key is accepted only after key_code has
//                     held the same nonzero value for DEBOUNCE_CYCLES cycles,
//                     and re-arming needs DEBOUNCE_CYCLES cycles of code 0.
//                     When undefined, a single-cycle 0 -> nonzero edge is a
//                     press and DEBOUNCE_CYCLES is unused.
//
// Ports:
//   clk           in   system clock
//   reset         in   synchronous, active-high reset
//   key_code      in   [3:0] 0 none, 1-9 digits, 15 digit 0, 10 '+', 11 '-',
//                      12 '*', 13 '/', 14 '='
//   operand_a     out  [WIDTH-1:0] first operand, stable while op_valid
//   operand_b     out  [WIDTH-1:0] second operand, stable while op_valid
//   opcode        out  [1:0] 00 add, 01 sub, 10 mul, 11 div
//   op_valid      out  operation available to the arithmetic unit
//   op_ready      in   arithmetic unit accepts the operation
//   display_value out  [WIDTH-1:0] operand currently being entered
//   entry_state   out  [1:0] 00 S_A, 01 S_B, 10 S_ISSUE
// -----------------------------------------------------------------------------
module calc_key_sequencer #(
    parameter int WIDTH           = 16,
    parameter int MAX_DIGITS      = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       key_code,
    output logic [WIDTH-1:0] operand_a,
    output logic [WIDTH-1:0] operand_b,
    output logic [1:0]       opcode,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [WIDTH-1:0] display_value,
    output logic [1:0]       entry_state
);

    // Digit counters must be able to hold the value MAX_DIGITS itself.
    localparam int                CNT_W   = $clog2(MAX_DIGITS + 1);
    localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_DIGITS);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        S_A     = 2'b00,
        S_B     = 2'b01,
        S_ISSUE = 2'b10
    } state_t;

    // -------------------------------------------------------------------------
    // Operand append: value*10 + digit, with code 15 standing for digit 0.
    // The multiply is built from two shifts; the MAX_DIGITS/WIDTH relation
    // guarantees the result never overflows.
    // -------------------------------------------------------------------------
    function automatic logic [WIDTH-1:0] append_digit(
        input logic [WIDTH-1:0] value,
        input logic [3:0]       code
    );
        logic [3:0]       digit;
        logic [WIDTH-1:0] times_ten;
        digit     = (code == 4'd15) ? 4'd0 : code;
        times_ten = (value << 3) + (value << 1);
        return times_ten + {{(WIDTH-4){1'b0}}, digit};
    endfunction

    // Registered state and datapath
    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [CNT_W-1:0]   r_cnt_a;
    logic [CNT_W-1:0]   r_cnt_b;
    logic [1:0]         r_opcode;
    logic               r_valid;
    logic [WIDTH-1:0]   r_display;
    logic [3:0]         r_prev_key;

    // Key classification and acceptance strobe
    logic               w_accept;
    logic               w_is_digit;
    logic               w_is_op;
    logic               w_is_eq;
    logic [1:0]         w_key_opcode;
    logic [WIDTH-1:0]   w_a_next;
    logic [WIDTH-1:0]   w_b_next;

    // Classify the raw key code; only meaningful when w_accept is high.
    always_comb begin
        w_is_digit   = ((key_code >= 4'd1) && (key_code <= 4'd9)) || (key_code == 4'd15);
        w_is_op      = (key_code >= 4'd10) && (key_code <= 4'd13);
        w_is_eq      = (key_code == 4'd14);
        // Codes 10..13 have low bits 10,11,00,01; adding 2 (mod 4) gives 00..11.
        w_key_opcode = key_code[1:0] + 2'd2;
        w_a_next     = append_digit(r_a, key_code);
        w_b_next     = append_digit(r_b, key_code);
    end

`ifdef KEY_DEBOUNCE_EN
    // Run length of identical consecutive samples, saturating at the window.
    localparam int               RUN_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [RUN_W-1:0] RUN_FULL = RUN_W'(DEBOUNCE_CYCLES);
    localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);

    logic [RUN_W-1:0] r_run;
    logic             r_armed;
    logic [RUN_W-1:0] w_run_next;

    // Length of the current run of identical key codes including this sample.
    always_comb begin
        if (key_code == r_prev_key) begin
            if (r_run == RUN_FULL) begin
                w_run_next = RUN_FULL;
            end else begin
                w_run_next = r_run + RUN_ONE;
            end
        end else begin
            w_run_next = RUN_ONE;
        end
        // Accept exactly at the edge that completes a stable nonzero window.
        w_accept = r_armed && (key_code != 4'd0) && (w_run_next == RUN_FULL);
    end

    // Debounce tracker: previous sample, run length and re-arm flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev_key <= 4'd0;
            r_run      <= {RUN_W{1'b0}};
            r_armed    <= 1'b1;
        end else begin
            r_prev_key <= key_code;
            r_run      <= w_run_next;
            if (w_accept) begin
                r_armed <= 1'b0;
            end else if ((key_code == 4'd0) && (w_run_next == RUN_FULL)) begin
                r_armed <= 1'b1;
            end else begin
                r_armed <= r_armed;
            end
        end
    end
`else
    // The window length only matters for the debounced press detector.
    logic w_unused_debounce;
    assign w_unused_debounce = (DEBOUNCE_CYCLES > 0);

    // A press is a nonzero code following a zero code on the previous edge.
    always_comb begin
        w_accept = (key_code != 4'd0) && (r_prev_key == 4'd0);
    end

    // Previous-key register; it keeps tracking in every entry state so a key
    // held through S_ISSUE is not seen as a fresh press afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev_key <= 4'd0;
        end else begin
            r_prev_key <= key_code;
        end
    end
`endif

    // Entry FSM with its operand, count, opcode, valid and display registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_A;
            r_a       <= {WIDTH{1'b0}};
            r_b       <= {WIDTH{1'b0}};
            r_cnt_a   <= {CNT_W{1'b0}};
            r_cnt_b   <= {CNT_W{1'b0}};
            r_opcode  <= 2'b00;
            r_valid   <= 1'b0;
            r_display <= {WIDTH{1'b0}};
        end else begin
            case (r_state)
                S_A: begin
                    if (w_accept && w_is_digit) begin
                        // Digits past MAX_DIGITS are dropped without effect.
                        if (r_cnt_a < MAX_CNT) begin
                            r_a       <= w_a_next;
                            r_cnt_a   <= r_cnt_a + CNT_ONE;
                            r_display <= w_a_next;
                        end else begin
                            r_a <= r_a;
                        end
                    end else if (w_accept && w_is_op) begin
                        // A with no digits is already 0, so nothing to fix up.
                        r_opcode  <= w_key_opcode;
                        r_state   <= S_B;
                        r_display <= r_b;
                    end else begin
                        r_state <= S_A;
                    end
                end

                S_B: begin
                    if (w_accept && w_is_digit) begin
                        if (r_cnt_b < MAX_CNT) begin
                            r_b       <= w_b_next;
                            r_cnt_b   <= r_cnt_b + CNT_ONE;
                            r_display <= w_b_next;
                        end else begin
                            r_b <= r_b;
                        end
                    end else if (w_accept && w_is_op) begin
                        // Operator may be corrected only until B has a digit.
                        if (r_cnt_b == {CNT_W{1'b0}}) begin
                            r_opcode <= w_key_opcode;
                        end else begin
                            r_opcode <= r_opcode;
                        end
                    end else if (w_accept && w_is_eq) begin
                        if (r_cnt_b != {CNT_W{1'b0}}) begin
                            r_state <= S_ISSUE;
                            r_valid <= 1'b1;
                        end else begin
                            r_state <= S_B;
                        end
                    end else begin
                        r_state <= S_B;
                    end
                end

                S_ISSUE: begin
                    // Everything is frozen until the handshake completes.
                    if (r_valid && op_ready) begin
                        r_state   <= S_A;
                        r_valid   <= 1'b0;
                        r_a       <= {WIDTH{1'b0}};
                        r_b       <= {WIDTH{1'b0}};
                        r_cnt_a   <= {CNT_W{1'b0}};
                        r_cnt_b   <= {CNT_W{1'b0}};
                        r_display <= {WIDTH{1'b0}};
                    end else begin
                        r_state <= S_ISSUE;
                    end
                end

                default: begin
                    r_state   <= S_A;
                    r_valid   <= 1'b0;
                    r_a       <= {WIDTH{1'b0}};
                    r_b       <= {WIDTH{1'b0}};
                    r_cnt_a   <= {CNT_W{1'b0}};
                    r_cnt_b   <= {CNT_W{1'b0}};
                    r_display <= {WIDTH{1'b0}};
                end
            endcase
        end
    end

    // All outputs come straight from registers.
    assign operand_a     = r_a;
    assign operand_b     = r_b;
    assign opcode        = r_opcode;
    assign op_valid      = r_valid;
    assign display_value = r_display;
    assign entry_state   = r_state;

endmodule

// File: tb/tb_calc_key_sequencer.sv
// -----------------------------------------------------------------------------
// tb_calc_key_sequencer
//
// Self-checking bench for calc_key_sequencer. A behavioural model tracks the
// calculator with plain integers (operands, digit counts, entry phase) and
// the press rule; directed scenarios compare against constants and the
// randomized scenario compares every cycle against the model.
// -----------------------------------------------------------------------------
module tb_calc_key_sequencer;

    localparam int WIDTH = 16;
    localparam int MAXD  = 4;
    localparam int DEB   = 4;
    localparam int HOLD  = 4;
    localparam int GAP   = 4;

    logic             clk;
    logic             reset;
    logic [3:0]       key_code;
    logic             op_ready;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic [1:0]       opcode;
    logic             op_valid;
    logic [WIDTH-1:0] display_value;
    logic [1:0]       entry_state;

    int total = 0;
    int bad   = 0;

    // Model state: phase 0 = entering A, 1 = entering B, 2 = issuing
    int m_a, m_b, m_na, m_nb, m_phase, m_opc, m_prev;
    int m_hist [DEB];
    bit m_armed;

    calc_key_sequencer #(
        .WIDTH(WIDTH),
        .MAX_DIGITS(MAXD),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .key_code(key_code),
        .operand_a(operand_a),
        .operand_b(operand_b),
        .opcode(opcode),
        .op_valid(op_valid),
        .op_ready(op_ready),
        .display_value(display_value),
        .entry_state(entry_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the model by one clock edge with the given inputs.
    task automatic model_update(input int code, input bit rdy, input bit rst);
        bit acc;
        bit same;
        bit is_digit;
        int dv;
        if (rst) begin
            m_a = 0; m_b = 0; m_na = 0; m_nb = 0; m_phase = 0; m_opc = 0;
            m_prev = 0; m_armed = 1'b1;
            for (int i = 0; i < DEB; i++) m_hist[i] = -1;
        end else begin
`ifdef KEY_DEBOUNCE_EN
            for (int i = 0; i < DEB - 1; i++) m_hist[i] = m_hist[i+1];
            m_hist[DEB-1] = code;
            same = 1'b1;
            for (int i = 0; i < DEB; i++) if (m_hist[i] != code) same = 1'b0;
            acc = m_armed && (code != 0) && same;
            if (acc) m_armed = 1'b0;
            else if (code == 0 && same) m_armed = 1'b1;
`else
            same = 1'b0;
            acc = (code != 0) && (m_prev == 0);
`endif
            m_prev   = code;
            is_digit = (code >= 1 && code <= 9) || code == 15;
            dv       = (code == 15) ? 0 : code;
            if (m_phase == 2) begin
                if (rdy) begin
                    m_a = 0; m_b = 0; m_na = 0; m_nb = 0; m_phase = 0;
                end
            end else if (acc) begin
                if (m_phase == 0) begin
                    if (is_digit) begin
                        if (m_na < MAXD) begin m_a = m_a * 10 + dv; m_na++; end
                    end else if (code >= 10 && code <= 13) begin
                        m_opc = code - 10; m_phase = 1;
                    end
                end else begin
                    if (is_digit) begin
                        if (m_nb < MAXD) begin m_b = m_b * 10 + dv; m_nb++; end
                    end else if (code >= 10 && code <= 13) begin
                        if (m_nb == 0) m_opc = code - 10;
                    end else if (code == 14) begin
                        if (m_nb > 0) m_phase = 2;
                    end
                end
            end
        end
    endtask

    // One clock: drive inputs, let the edge happen, update model, settle.
    task automatic step(input int code, input bit rdy);
        key_code = 4'(code);
        op_ready = rdy;
        @(posedge clk);
        model_update(code, rdy, reset);
        #1;
    endtask

    // A full key press: held HOLD cycles then released GAP cycles.
    task automatic press(input int code);
        for (int i = 0; i < HOLD; i++) step(code, 1'b0);
        for (int i = 0; i < GAP; i++) step(0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(0, 1'b0);
        step(0, 1'b0);
        reset = 1'b0;
        total++; if (op_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0d want=0", op_valid); end
        total++; if (operand_a !== '0) begin bad++; $display("FAIL reset_a got=%0d want=0", operand_a); end
        total++; if (operand_b !== '0) begin bad++; $display("FAIL reset_b got=%0d want=0", operand_b); end
        total++; if (opcode !== 2'b00) begin bad++; $display("FAIL reset_opcode got=%0d want=0", opcode); end
        total++; if (display_value !== '0) begin bad++; $display("FAIL reset_display got=%0d want=0", display_value); end
        total++; if (entry_state !== 2'b00) begin bad++; $display("FAIL reset_state got=%0d want=0", entry_state); end
    endtask

    task automatic test_basic();
        press(1);
        total++; if (display_value !== 16'd1) begin bad++; $display("FAIL basic_disp1 got=%0d want=1", display_value); end
        press(2);
        press(10);
        total++; if (entry_state !== 2'b01 || display_value !== 16'd0) begin bad++; $display("FAIL basic_sb got state=%0d disp=%0d want 1/0", entry_state, display_value); end
        press(3);
        press(14);
        total++; if (op_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0d want=1", op_valid); end
        total++; if (operand_a !== 16'd12 || operand_b !== 16'd3 || opcode !== 2'b00) begin
            bad++; $display("FAIL basic_ops got a=%0d b=%0d op=%0d want 12/3/0", operand_a, operand_b, opcode); end
        total++; if (entry_state !== 2'b10) begin bad++; $display("FAIL basic_issue_state got=%0d want=2", entry_state); end
        step(0, 1'b1);
        total++; if (op_valid !== 1'b0 || entry_state !== 2'b00 || display_value !== 16'd0) begin
            bad++; $display("FAIL basic_accept got v=%0d st=%0d disp=%0d want 0/0/0", op_valid, entry_state, display_value); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 5; i++) press(9);
        total++; if (display_value !== 16'd9999 || entry_state !== 2'b00) begin
            bad++; $display("FAIL overflow_disp got=%0d st=%0d want 9999/0", display_value, entry_state); end
        press(10); press(1); press(14);
        total++; if (operand_a !== 16'd9999 || operand_b !== 16'd1 || op_valid !== 1'b1) begin
            bad++; $display("FAIL overflow_ops got a=%0d b=%0d v=%0d want 9999/1/1", operand_a, operand_b, op_valid); end
        step(0, 1'b1);
    endtask

    task automatic test_replace();
        press(5); press(10); press(11); press(2); press(12); press(14);
        total++; if (opcode !== 2'b01 || operand_a !== 16'd5 || operand_b !== 16'd2 || op_valid !== 1'b1) begin
            bad++; $display("FAIL replace got op=%0d a=%0d b=%0d v=%0d want 1/5/2/1", opcode, operand_a, operand_b, op_valid); end
        step(0, 1'b1);
    endtask

    task automatic test_eq_ignored();
        press(7); press(11); press(14);
        total++; if (entry_state !== 2'b01 || op_valid !== 1'b0 || display_value !== 16'd0) begin
            bad++; $display("FAIL eq_ignored got st=%0d v=%0d disp=%0d want 1/0/0", entry_state, op_valid, display_value); end
        press(15); press(14);
        total++; if (op_valid !== 1'b1 || operand_a !== 16'd7 || operand_b !== 16'd0 || opcode !== 2'b01) begin
            bad++; $display("FAIL zero_b got v=%0d a=%0d b=%0d op=%0d want 1/7/0/1", op_valid, operand_a, operand_b, opcode); end
        step(0, 1'b1);
    endtask

    task automatic test_hold_reset();
        press(6); press(12); press(8); press(14);
        for (int cyc = 1; cyc <= 10; cyc++) begin
            reset = (cyc == 5);
            step((cyc % 3 != 0) ? 4 : 0, 1'b0);
            reset = 1'b0;
            if (cyc < 5) begin
                total++;
                if ({op_valid, operand_a, operand_b, opcode, display_value, entry_state} !==
                    {1'b1, 16'd6, 16'd8, 2'd2, 16'd8, 2'd2}) begin
                    bad++; $display("FAIL hold_issue cyc=%0d got v=%0d a=%0d b=%0d op=%0d disp=%0d want 1/6/8/2/8", cyc, op_valid, operand_a, operand_b, opcode, display_value);
                end
            end else if (cyc == 5) begin
                total++;
                if ({op_valid, operand_a, operand_b, opcode, display_value, entry_state} !== '0) begin
                    bad++; $display("FAIL hold_reset got v=%0d a=%0d b=%0d op=%0d disp=%0d st=%0d want all 0", op_valid, operand_a, operand_b, opcode, display_value, entry_state);
                end
            end else begin
                total++;
                if (op_valid !== 1'b0 || display_value !== WIDTH'(m_a)) begin
                    bad++; $display("FAIL after_reset cyc=%0d got v=%0d disp=%0d want 0/%0d", cyc, op_valid, display_value, m_a);
                end
            end
        end
        for (int i = 0; i < 3; i++) step(0, 1'b1);
        total++; if (op_valid !== 1'b0) begin bad++; $display("FAIL no_issue got=%0d want=0", op_valid); end
        reset = 1'b1; step(0, 1'b0); reset = 1'b0;
    endtask

    task automatic test_random();
        int code, hold, gap, r;
        for (int n = 0; n < 250; n++) begin
            r = $urandom_range(99);
            if (r < 60) begin
                code = $urandom_range(9);
                if (code == 0) code = 15;
            end else if (r < 85) begin
                code = 10 + $urandom_range(3);
            end else begin
                code = 14;
            end
            hold = $urandom_range(6, 1);
            gap  = $urandom_range(5, 0);
            for (int c = 0; c < hold + gap; c++) begin
                step((c < hold) ? code : 0, ($urandom_range(3) == 0));
                total++;
                if (display_value !== WIDTH'((m_phase == 0) ? m_a : m_b) ||
                    entry_state !== 2'(m_phase) || op_valid !== (m_phase == 2)) begin
                    bad++; $display("FAIL rand_entry n=%0d got disp=%0d st=%0d v=%0d want %0d/%0d/%0d", n, display_value, entry_state, op_valid, (m_phase == 0) ? m_a : m_b, m_phase, m_phase == 2);
                end
                if (m_phase == 2) begin
                    total++;
                    if (operand_a !== WIDTH'(m_a) || operand_b !== WIDTH'(m_b) || opcode !== 2'(m_opc)) begin
                        bad++; $display("FAIL rand_issue n=%0d got a=%0d b=%0d op=%0d want %0d/%0d/%0d", n, operand_a, operand_b, opcode, m_a, m_b, m_opc);
                    end
                end
            end
        end
    endtask

`ifdef KEY_DEBOUNCE_EN
    task automatic test_debounce();
        reset = 1'b1; step(0, 1'b0); reset = 1'b0;
        for (int i = 0; i < 3; i++) step(3, 1'b0);
        for (int i = 0; i < 4; i++) step(0, 1'b0);
        total++; if (display_value !== 16'd0) begin bad++; $display("FAIL deb_short got=%0d want=0", display_value); end
        for (int i = 0; i < 4; i++) step(3, 1'b0);
        total++; if (display_value !== 16'd3) begin bad++; $display("FAIL deb_accept got=%0d want=3", display_value); end
        for (int i = 0; i < 2; i++) step(0, 1'b0);
        for (int i = 0; i < 4; i++) step(3, 1'b0);
        total++; if (display_value !== 16'd3) begin bad++; $display("FAIL deb_rearm got=%0d want=3", display_value); end
        reset = 1'b1; step(0, 1'b0); reset = 1'b0;
    endtask
`endif

    initial begin
        reset    = 1'b0;
        key_code = 4'd0;
        op_ready = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_replace();
        test_eq_ignored();
        test_hold_reset();
`ifdef KEY_DEBOUNCE_EN
        test_debounce();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
